// File: rtl/logic_pkg.sv
// Shared definitions for the serial logic-unit sequencer.
//   - Opcode encodings {sel_1,sel_2,sel_3} understood by the 1-bit logic unit.
//   - Sequencer FSM state type.
//   - ref_logic(): word-level behaviour of the logic unit, used as a golden model.
package logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;  // NOT(B), A ignored
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_RSVD = 3'b110;  // unit returns 0 for every bit
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bitwise result of applying op to a/b, truncated to the low w bits.
    function automatic logic [31:0] ref_logic(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0]  op,
                                              input int unsigned w);
        logic [31:0] r;
        logic [31:0] mask;
        case (op)
            OP_NOT:  r = ~b;
            OP_AND:  r = a & b;
            OP_NAND: r = ~(a & b);
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = '0;
        endcase
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return r & mask;
    endfunction

endpackage

// File: rtl/logic_serial_sequencer_if.sv
// Command and result handshakes of the serial logic-unit sequencer.
//   in_valid/in_ready  : command handshake carrying in_a, in_b (W bits) and in_op (3 bits)
//   out_valid/out_ready: result handshake carrying out_data (W bits) and out_illegal
// Modports: master = upstream/downstream agent, slave = sequencer.
interface logic_serial_sequencer_if #(
    parameter int unsigned W = 8
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_illegal
    );

endinterface

// File: rtl/serial_shift_capture.sv
// Datapath of the serial sequencer: operand shift registers, bit counter and result capture.
//   load_i     : latch operands/opcode, clear counter and result
//   step_i     : capture lu_s_i into result[cnt], advance operands and counter
//   bit_a_o/bit_b_o : current operand bits (A[cnt], B[cnt])
//   op_o       : latched opcode
//   last_o     : counter is on the final bit (cnt == W-1)
//   result_o   : captured result word
module serial_shift_capture #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    input  logic         lu_s_i,
    output logic         bit_a_o,
    output logic         bit_b_o,
    output logic [2:0]   op_o,
    output logic         last_o,
    output logic [W-1:0] result_o
);

    localparam int unsigned CntW = $clog2(W);

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (load_i) begin
            a_d      = a_i;
            b_d      = b_i;
            op_d     = op_i;
            cnt_d    = '0;
            result_d = '0;
        end else if (step_i) begin
            // Operands shift right so bit 0 always holds A[cnt]/B[cnt].
            a_d              = {1'b0, a_q[W-1:1]};
            b_d              = {1'b0, b_q[W-1:1]};
            result_d[cnt_q]  = lu_s_i;
            cnt_d            = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bit_a_o  = a_q[0];
    assign bit_b_o  = b_q[0];
    assign op_o     = op_q;
    assign last_o   = (cnt_q == CntW'(W - 1));
    assign result_o = result_q;

endmodule

// File: rtl/logic_serial_sequencer.sv
// Serial front-end for a 1-bit 3-select logic unit. Accepts a W-bit operand pair and opcode,
// feeds the unit one bit per cycle (LSB first) for W cycles, collects its output into a word
// and presents the word downstream.
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : command and result handshakes
//   busy           : high in RUN or DONE
//   lu_a/lu_b/lu_sel : drive the external logic unit (zero outside RUN)
//   lu_s           : combinational result from the logic unit
module logic_serial_sequencer
    import logic_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    logic_serial_sequencer_if.slave        bus,
    output logic                           busy,
    output logic                           lu_a,
    output logic                           lu_b,
    output logic [2:0]                     lu_sel,
    input  logic                           lu_s
);

    state_e       state_q, state_d;
    logic         load, step, last;
    logic         bit_a, bit_b;
    logic [2:0]   op;
    logic [W-1:0] result;

    serial_shift_capture #(
        .W (W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .a_i      (bus.in_a),
        .b_i      (bus.in_b),
        .op_i     (bus.in_op),
        .lu_s_i   (lu_s),
        .bit_a_o  (bit_a),
        .bit_b_o  (bit_b),
        .op_o     (op),
        .last_o   (last),
        .result_o (result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        busy            = (state_q != IDLE);
        load            = (state_q == IDLE) && bus.in_valid;
        step            = (state_q == RUN);
        bus.out_valid   = (state_q == DONE);
        // Result outputs are forced to zero unless presenting a completed word.
        bus.out_data    = (state_q == DONE) ? result : '0;
        bus.out_illegal = (state_q == DONE) && (op == OP_RSVD);
        lu_a            = (state_q == RUN) ? bit_a : 1'b0;
        lu_b            = (state_q == RUN) ? bit_b : 1'b0;
        lu_sel          = (state_q == RUN) ? op : 3'b000;
    end

endmodule

// File: tb/tb_logic_serial_sequencer.sv
// Self-checking bench for logic_serial_sequencer with a behavioural 1-bit logic unit beside it.
module tb_logic_serial_sequencer;
    import logic_pkg::*;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       lu_a, lu_b, lu_s;
    logic [2:0] lu_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_serial_sequencer_if #(.W(W)) bus ();

    logic_serial_sequencer #(
        .W (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .lu_a   (lu_a),
        .lu_b   (lu_b),
        .lu_sel (lu_sel),
        .lu_s   (lu_s)
    );

    // 1-bit logic unit truth table.
    always_comb begin
        case (lu_sel)
            3'b000:  lu_s = ~lu_b;
            3'b001:  lu_s = lu_a & lu_b;
            3'b010:  lu_s = ~(lu_a & lu_b);
            3'b011:  lu_s = lu_a | lu_b;
            3'b100:  lu_s = ~(lu_a | lu_b);
            3'b101:  lu_s = lu_a ^ lu_b;
            3'b110:  lu_s = 1'b0;
            default: lu_s = ~(lu_a ^ lu_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_noise(input bit noise);
        if (noise) begin
            bus.in_valid = 1'($urandom);
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
            bus.in_op    = 3'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           input int stall, input bit noise);
        logic [31:0] exp_word;
        logic        exp_ill;
        exp_word = ref_logic(32'(a), 32'(b), op, W);
        exp_ill  = (op == OP_RSVD);

        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        @(negedge clk);

        for (int i = 0; i < int'(W); i++) begin
            drive_noise(noise);
            check("busy_run", 32'(busy), 32'd1);
            check("in_ready_run", 32'(bus.in_ready), 32'd0);
            check("out_valid_run", 32'(bus.out_valid), 32'd0);
            check("lu_a", 32'(lu_a), 32'(a[i]));
            check("lu_b", 32'(lu_b), 32'(b[i]));
            check("lu_sel", 32'(lu_sel), 32'(op));
            @(negedge clk);
        end

        for (int s = 0; s <= stall; s++) begin
            check("out_valid_done", 32'(bus.out_valid), 32'd1);
            check("out_data", 32'(bus.out_data), exp_word);
            check("out_illegal", 32'(bus.out_illegal), 32'(exp_ill));
            check("in_ready_done", 32'(bus.in_ready), 32'd0);
            check("busy_done", 32'(busy), 32'd1);
            if (s < stall) begin
                drive_noise(noise);
                bus.out_ready = 1'b0;
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("out_valid_drain", 32'(bus.out_valid), 32'd0);
        check("in_ready_drain", 32'(bus.in_ready), 32'd1);
        check("busy_drain", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lu_sel", 32'(lu_sel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, with independent expected words alongside the reference model.
        check("ref_and", ref_logic(32'hF0, 32'hCC, OP_AND, W), 32'hC0);
        run_cmd(8'hF0, 8'hCC, OP_AND, 0, 1'b0);
        run_cmd(8'h3C, 8'h0F, OP_NOT, 0, 1'b1);
        run_cmd(8'hFF, 8'h0F, OP_NAND, 0, 1'b1);
        run_cmd(8'hA5, 8'h5A, OP_XNOR, 0, 1'b0);
        run_cmd(8'h00, 8'h00, OP_NOR, 1, 1'b0);
        run_cmd(8'h12, 8'h21, OP_OR, 0, 1'b0);
        run_cmd(8'hFF, 8'hFF, OP_RSVD, 0, 1'b0);
        run_cmd(8'h96, 8'h3C, OP_XOR, 5, 1'b1);

        // Reset while the counter sits at 3 in RUN.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h5A;
        bus.in_b     = 8'h3C;
        bus.in_op    = OP_OR;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'd0);
        check("abort_out_illegal", 32'(bus.out_illegal), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_lu", {28'd0, lu_a, lu_b, lu_sel[1:0]} | 32'(lu_sel[2]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < int'(W) + 2; i++) begin
            check("abort_no_output", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        run_cmd(8'h5A, 8'h3C, OP_OR, 0, 1'b0);

        // Randomised commands, stalls and ignored input traffic.
        for (int k = 0; k < 40; k++) begin
            run_cmd(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
